octopos_domain_reset_ctrl: RTL

- Parametrised successor to the single-output reset module. Issues a software-requested reset to one of NUM_DOM domains, and only once the system is quiescent.
- Quiescent means: all NUM_MBOX mailboxes idle and the target domain not busy.
- Reset pulse length is bounded and counted. Waiting for quiescence is bounded by a timeout.
- Sits between the register front-end (which drives the req handshake) and the per-domain reset inputs.

---
 rtl/octopos_reset_pkg.sv | 22 ++
 rtl/octopos_domain_reset_ctrl_if.sv | 32 +++
 rtl/octopos_quiet_filter.sv | 32 +++
 rtl/octopos_domain_reset_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/octopos_reset_pkg.sv
// Shared types and constants for the per-domain reset controller.
// Optional feature macro: OCTOPOS_RESET_FORCE_EN (consumed by the top).
package octopos_reset_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ASSERT = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BADIDX  = 2'b10;
    localparam logic [1:0] ST_FORCED  = 2'b11;

    // Width of a domain index; a single domain still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/octopos_domain_reset_ctrl_if.sv
// Request/completion handshake between the register front-end (master)
// and the domain reset controller (slave).
interface octopos_domain_reset_ctrl_if
    import octopos_reset_pkg::*;
#(
    parameter int NUM_DOM = 8
) ();
    localparam int DOM_W = idx_width(NUM_DOM);

    logic             req_valid;
    logic             req_ready;
    logic [DOM_W-1:0] req_dom;
    logic             done_valid;
    logic [1:0]       done_status;

    modport master (
        output req_valid,
        output req_dom,
        input  req_ready,
        input  done_valid,
        input  done_status
    );

    modport slave (
        input  req_valid,
        input  req_dom,
        output req_ready,
        output done_valid,
        output done_status
    );

endinterface

// File: rtl/octopos_quiet_filter.sv
// Debouncer: stable is high once QUIET_CYCLES consecutive quiet samples
// (including the current one) have been seen since the last clear.
module octopos_quiet_filter #(
    parameter int QUIET_CYCLES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic quiet,
    output logic stable
);
    localparam int              QW     = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0]   Q_LAST = QW'(QUIET_CYCLES - 1);

    logic [QW-1:0] quiet_cnt_r;

    // Run-length of quiet samples, saturating at the terminal value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            quiet_cnt_r <= '0;
        end else if (clear || !quiet) begin
            quiet_cnt_r <= '0;
        end else if (quiet_cnt_r != Q_LAST) begin
            quiet_cnt_r <= quiet_cnt_r + QW'(1);
        end else begin
            quiet_cnt_r <= quiet_cnt_r;
        end
    end

    assign stable = quiet && (quiet_cnt_r == Q_LAST);

endmodule

// File: rtl/octopos_domain_reset_ctrl.sv
// Issues a software-requested reset pulse to one of NUM_DOM domains once
// mailboxes and the target are quiescent. Define OCTOPOS_RESET_FORCE_EN to
// force the pulse on a quiescence timeout instead of reporting it.
module octopos_domain_reset_ctrl
    import octopos_reset_pkg::*;
#(
    parameter int NUM_MBOX     = 4,
    parameter int NUM_DOM      = 8,
    parameter int RST_CYCLES   = 16,
    parameter int QUIET_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    octopos_domain_reset_ctrl_if.slave req_if,
    input  logic [NUM_MBOX-1:0]   mbox_busy_n,
    input  logic [NUM_DOM-1:0]    dom_busy,
    output logic [NUM_DOM-1:0]    dom_reset_n,
    output logic                  ctrl_busy
);
    localparam int DOM_W    = idx_width(NUM_DOM);
    localparam int DOM_SPAN = 1 << DOM_W;
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam int RC_W     = $clog2(RST_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    state_e            state_r;
    logic [DOM_W-1:0]  tgt_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic [RC_W-1:0]   rst_cnt_r;
    logic              force_r;
    logic              req_ready_r;
    logic              ctrl_busy_r;
    logic              done_valid_r;
    logic [1:0]        done_status_r;

    logic              all_idle_s;
    logic              quiet_s;
    logic              stable_s;
    logic              clear_s;
    logic              bad_idx_s;
    logic              gate_s;
    logic [DOM_SPAN-1:0] busy_pad_s;

    assign all_idle_s = &mbox_busy_n;
    assign clear_s    = (state_r != S_WAIT);

    // Pad busy vector to the full index range so tgt_r never indexes past it.
    always_comb begin
        busy_pad_s               = '0;
        busy_pad_s[NUM_DOM-1:0]  = dom_busy;
    end

    assign quiet_s = all_idle_s && !busy_pad_s[tgt_r];

    // Out-of-range indices only exist when NUM_DOM is not a power of two.
    generate
        if (DOM_SPAN > NUM_DOM) begin : g_badidx
            assign bad_idx_s = (int'(req_if.req_dom) >= NUM_DOM);
        end else begin : g_nobadidx
            assign bad_idx_s = 1'b0;
        end
    endgenerate

    octopos_quiet_filter #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet_filter (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear_s),
        .quiet  (quiet_s),
        .stable (stable_s)
    );

    // A forced pulse ignores the mailbox gate; otherwise a busy mailbox pauses it.
    assign gate_s = (state_r == S_ASSERT) && (force_r || all_idle_s);

    // Per-domain reset outputs: only the latched target can be pulled low.
    always_comb begin
        dom_reset_n = '1;
        for (int i = 0; i < NUM_DOM; i++) begin
            dom_reset_n[i] = !(gate_s && (int'(tgt_r) == i));
        end
    end

    // Control FSM with counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= S_IDLE;
            tgt_r         <= '0;
            to_cnt_r      <= '0;
            rst_cnt_r     <= '0;
            force_r       <= 1'b0;
            req_ready_r   <= 1'b1;
            ctrl_busy_r   <= 1'b0;
            done_valid_r  <= 1'b0;
            done_status_r <= ST_OK;
        end else begin
            done_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        tgt_r       <= req_if.req_dom;
                        to_cnt_r    <= '0;
                        rst_cnt_r   <= '0;
                        force_r     <= 1'b0;
                        req_ready_r <= 1'b0;
                        ctrl_busy_r <= 1'b1;
                        if (bad_idx_s) begin
                            state_r       <= S_DONE;
                            done_valid_r  <= 1'b1;
                            done_status_r <= ST_BADIDX;
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (to_cnt_r != TO_LAST) begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                    if (stable_s) begin
                        state_r   <= S_ASSERT;
                        rst_cnt_r <= '0;
                    end else if (to_cnt_r == TO_LAST) begin
`ifdef OCTOPOS_RESET_FORCE_EN
                        state_r   <= S_ASSERT;
                        rst_cnt_r <= '0;
                        force_r   <= 1'b1;
`else
                        state_r       <= S_DONE;
                        done_valid_r  <= 1'b1;
                        done_status_r <= ST_TIMEOUT;
`endif
                    end
                end
                S_ASSERT: begin
                    if (gate_s) begin
                        if (rst_cnt_r == RC_LAST) begin
                            state_r       <= S_DONE;
                            done_valid_r  <= 1'b1;
                            done_status_r <= force_r ? ST_FORCED : ST_OK;
                        end else begin
                            rst_cnt_r <= rst_cnt_r + RC_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_r     <= S_IDLE;
                    force_r     <= 1'b0;
                    req_ready_r <= 1'b1;
                    ctrl_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    force_r     <= 1'b0;
                    req_ready_r <= 1'b1;
                    ctrl_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_if.req_ready   = req_ready_r;
    assign req_if.done_valid  = done_valid_r;
    assign req_if.done_status = done_status_r;
    assign ctrl_busy          = ctrl_busy_r;

endmodule
